// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: output-buffer occupancy encoding and Gray/binary pointer helpers.
package fifo_pkg;

  typedef enum logic [1:0] {
    OccEmpty = 2'd0,
    OccOne   = 2'd1,
    OccTwo   = 2'd2
  } occ_e;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin = '0;
    for (int i = 0; i < 32; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter of configurable width.
module gray2bin #(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/rd_fwft_ctrl.sv
// Read side of an async FIFO: issues RAM reads against a synchronised write pointer and
// presents the head word first-word-fall-through via a two-entry head/skid buffer.
module rd_fwft_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH:0]   wr_gray_sync,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [ADDR_WIDTH:0]   rd_bin,
  output logic [ADDR_WIDTH:0]   rd_gray,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  ram_empty,
  output logic [ADDR_WIDTH+1:0] level
);

  localparam int unsigned PW = ADDR_WIDTH + 1;
  localparam int unsigned LW = ADDR_WIDTH + 2;

  logic [PW-1:0]         rd_bin_q, rd_bin_d;
  logic [PW-1:0]         rd_gray_q, rd_gray_d;
  logic                  inflight_q;
  occ_e                  occ_q, occ_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  dout_valid_q;
  logic [PW-1:0]         wr_bin;
  logic [PW-1:0]         ram_words;
  logic [1:0]            occ_sum;
  logic [1:0]            occ_after_pop;
  logic                  pop;
  logic                  issue;

  gray2bin #(
    .WIDTH (PW)
  ) u_wr_gray2bin (
    .gray (wr_gray_sync),
    .bin  (wr_bin)
  );

  assign ram_empty     = (rd_gray_q == wr_gray_sync);
  assign pop           = dout_valid_q & dout_ready;
  assign occ_after_pop = 2'(occ_q) - 2'(pop);
  // occ = 0 with pop cannot happen, so this never underflows
  assign occ_sum       = occ_after_pop + 2'(inflight_q);
  // Reads are held off during reset so a live write pointer cannot start a fetch.
  assign issue         = ~rst & ~ram_empty & (occ_sum <= 2'd1);

  assign mem_rd_en   = issue;
  assign mem_rd_addr = rd_bin_q[ADDR_WIDTH-1:0];
  assign rd_bin      = rd_bin_q;
  assign rd_gray     = rd_gray_q;
  assign dout        = head_q;
  assign dout_valid  = dout_valid_q;

  assign ram_words = wr_bin - rd_bin_q;
  assign level     = LW'(ram_words) + LW'(inflight_q) + LW'(occ_q);

  always_comb begin
    rd_bin_d  = rd_bin_q + PW'(issue);
    rd_gray_d = PW'(bin2gray(32'(rd_bin_d)));
    occ_d     = occ_e'(occ_sum);
    head_d    = head_q;
    skid_d    = skid_q;
    if (pop && (occ_q == OccTwo)) begin
      head_d = skid_q;
    end
    // Returning word lands in whichever slot is the first free one after this pop.
    if (inflight_q) begin
      if (occ_after_pop == 2'd0) begin
        head_d = mem_rd_data;
      end else begin
        skid_d = mem_rd_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bin_q     <= '0;
      rd_gray_q    <= '0;
      inflight_q   <= 1'b0;
      occ_q        <= OccEmpty;
      head_q       <= '0;
      skid_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      rd_bin_q     <= rd_bin_d;
      rd_gray_q    <= rd_gray_d;
      inflight_q   <= issue;
      occ_q        <= occ_d;
      head_q       <= head_d;
      skid_q       <= skid_d;
      dout_valid_q <= (occ_d != OccEmpty);
    end
  end

endmodule

// File: tb/tb_rd_fwft_ctrl.sv
// Scoreboard bench for rd_fwft_ctrl: a behavioural writer/RAM model feeds the DUT and a
// negedge monitor checks every popped word, the level and the pointer relations.
module tb_rd_fwft_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] wr_gray_sync;
  logic       mem_rd_en;
  logic [3:0] mem_rd_addr;
  logic [7:0] mem_rd_data;
  logic [4:0] rd_bin;
  logic [4:0] rd_gray;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       ram_empty;
  logic [5:0] level;

  logic [7:0] ram [16];
  logic [7:0] exp_q [$];
  logic [3:0] addr_log [$];
  logic [4:0] bin_log [$];
  logic [4:0] wr_ptr;
  int passed = 0;
  int total = 0;
  int written = 0;
  int popped = 0;
  int issue_cnt = 0;

  rd_fwft_ctrl #(
    .ADDR_WIDTH (4),
    .DATA_WIDTH (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_gray_sync (wr_gray_sync),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data),
    .rd_bin       (rd_bin),
    .rd_gray      (rd_gray),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .ram_empty    (ram_empty),
    .level        (level)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] to_gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic push_word(input logic [7:0] d);
    ram[wr_ptr[3:0]] = d;
    exp_q.push_back(d);
    wr_ptr = wr_ptr + 5'd1;
    written++;
    wr_gray_sync = to_gray(wr_ptr);
  endtask

  task automatic clear_model();
    exp_q.delete();
    wr_ptr = '0;
    wr_gray_sync = '0;
    written = 0;
    popped = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    dout_ready = 1'b1;
    while ((popped != written) && (n < 200)) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drained", 32'(popped), 32'(written));
  endtask

  task automatic rand_run(input int cycles, input int limit);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      dout_ready = ($urandom % 4) != 0;
      if ((($urandom % 2) == 1) && (written - popped < 16) && (written < limit)) begin
        push_word(8'($urandom));
      end
    end
  endtask

  // RAM: one-cycle read latency; garbage when not read so stray captures show up.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
    else mem_rd_data <= 8'($urandom);
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("level", 32'(level), 32'(written - popped));
      chk("rd_gray", 32'(rd_gray), 32'(to_gray(rd_bin)));
      if (mem_rd_en) begin
        chk("rd_addr", 32'(mem_rd_addr), 32'(rd_bin[3:0]));
        issue_cnt++;
        addr_log.push_back(mem_rd_addr);
        bin_log.push_back(rd_bin);
      end
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL spurious_pop: got %0h expected no word at %0t", dout, $time);
        end else begin
          chk("dout", 32'(dout), 32'(exp_q.pop_front()));
        end
        popped++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish within 1ms");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_addr [4];
    logic [4:0] exp_bin [4];
    exp_addr = '{4'd14, 4'd15, 4'd0, 4'd1};
    exp_bin  = '{5'd30, 5'd31, 5'd0, 5'd1};
    for (int i = 0; i < 16; i++) ram[i] = '0;
    rst = 1'b1;
    dout_ready = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_rd_bin", 32'(rd_bin), 32'd0);
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_empty", 32'(ram_empty), 32'd1);
      chk("idle_rd_en", 32'(mem_rd_en), 32'd0);
      chk("idle_valid", 32'(dout_valid), 32'd0);
      chk("idle_level", 32'(level), 32'd0);
    end

    // First word latency
    @(posedge clk);
    #1;
    push_word(8'hA5);
    @(negedge clk);
    chk("lat_rd_en", 32'(mem_rd_en), 32'd1);
    chk("lat_addr", 32'(mem_rd_addr), 32'd0);
    @(negedge clk);
    chk("lat_valid_c1", 32'(dout_valid), 32'd0);
    @(negedge clk);
    chk("lat_valid_c2", 32'(dout_valid), 32'd1);
    chk("lat_dout", 32'(dout), 32'hA5);
    chk("lat_rd_bin", 32'(rd_bin), 32'd1);
    chk("lat_level", 32'(level), 32'd1);

    // Four more words, streamed out
    @(posedge clk);
    #1;
    for (int i = 1; i < 5; i++) push_word(8'(8'h10 + i));
    dout_ready = 1'b1;
    drain();
    @(negedge clk);
    chk("five_valid", 32'(dout_valid), 32'd0);
    chk("five_level", 32'(level), 32'd0);

    // Full RAM with stalled consumer, then a gapless stream
    @(posedge clk);
    #1;
    rst = 1'b1;
    dout_ready = 1'b0;
    clear_model();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    issue_cnt = 0;
    for (int i = 0; i < 16; i++) push_word(8'($urandom));
    repeat (8) @(negedge clk);
    chk("full_issues", 32'(issue_cnt), 32'd2);
    chk("full_rd_bin", 32'(rd_bin), 32'd2);
    chk("full_level", 32'(level), 32'd16);
    chk("full_valid", 32'(dout_valid), 32'd1);
    @(posedge clk);
    #1;
    dout_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("stream_valid", 32'(dout_valid), 32'd1);
    end
    @(negedge clk);
    chk("stream_end_valid", 32'(dout_valid), 32'd0);
    chk("stream_end_level", 32'(level), 32'd0);

    // Advance to rd_bin = 30 with random traffic, then cross the wrap
    rand_run(200, 30);
    for (int n = 0; (n < 200) && (written < 30); n++) rand_run(1, 30);
    drain();
    @(negedge clk);
    chk("pre_wrap_rd_bin", 32'(rd_bin), 32'd30);
    @(posedge clk);
    #1;
    addr_log.delete();
    bin_log.delete();
    for (int i = 0; i < 4; i++) push_word(8'($urandom));
    drain();
    @(negedge clk);
    chk("wrap_count", 32'(addr_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < addr_log.size()) begin
        chk("wrap_addr", 32'(addr_log[i]), 32'(exp_addr[i]));
        chk("wrap_bin", 32'(bin_log[i]), 32'(exp_bin[i]));
      end
    end
    chk("wrap_rd_bin", 32'(rd_bin), 32'd2);
    chk("wrap_rd_gray", 32'(rd_gray), 32'b00011);

    // Long random run over several wraps
    rand_run(1500, 1 << 30);
    drain();

    // Reset with a full output buffer and a live write pointer
    @(posedge clk);
    #1;
    dout_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(8'($urandom));
    repeat (4) @(posedge clk);
    #1;
    dout_ready = 1'b1;
    @(posedge clk);
    #3;
    rst = 1'b1;
    clear_model();
    for (int i = 0; i < 3; i++) push_word(8'(8'hC0 + i));
    #1;
    chk("mid_rst_valid", 32'(dout_valid), 32'd0);
    chk("mid_rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("mid_rst_rd_bin", 32'(rd_bin), 32'd0);
    chk("mid_rst_rd_gray", 32'(rd_gray), 32'd0);
    chk("mid_rst_dout", 32'(dout), 32'd0);
    chk("mid_rst_level", 32'(level), 32'd3);
    @(negedge clk);
    chk("rst_hold_rd_en", 32'(mem_rd_en), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drain();
    chk("post_rst_pops", 32'(popped), 32'd3);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rd_fwft_ctrl.md
RD_FWFT_CTRL -- requirements
Module: rd_fwft_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, RAM address width; depth 2^ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, RAM word width.
REQ-003 clk  input  1  read-domain clock; the block has only one clock.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 wr_gray_sync  input  ADDR_WIDTH+1  write pointer, Gray coded, already synchronised into clk.
REQ-006 mem_rd_en  output  1  RAM read strobe; data returns exactly 1 cycle later.
REQ-007 mem_rd_addr  output  ADDR_WIDTH  RAM read address, equals rd_bin[ADDR_WIDTH-1:0].
REQ-008 mem_rd_data  input  DATA_WIDTH  RAM read data.
REQ-009 rd_bin  output  ADDR_WIDTH+1  registered binary read pointer.
REQ-010 rd_gray  output  ADDR_WIDTH+1  registered Gray read pointer, sent to the write-side synchroniser.
REQ-011 dout  output  DATA_WIDTH  head word, first-word-fall-through.
REQ-012 dout_valid  output  1  dout holds a valid word.
REQ-013 dout_ready  input  1  consumer accepts dout; pop = dout_valid & dout_ready.
REQ-014 ram_empty  output  1  no unread word in RAM.
REQ-015 level  output  ADDR_WIDTH+2  total words held: RAM + in-flight + output buffer.

Function
REQ-016 ram_empty SHALL be combinational: rd_gray == wr_gray_sync.
REQ-017 Output buffer SHALL be 2 entries (head, skid) with occupancy occ in {0,1,2}; states EMPTY, ONE, TWO.
REQ-018 inflight SHALL be a 1-bit register, set when mem_rd_en is asserted, cleared otherwise.
REQ-019 issue = ~ram_empty & (occ + inflight - pop <= 1); mem_rd_en SHALL equal issue.
REQ-020 On issue, rd_bin SHALL increment by 1 modulo 2^(ADDR_WIDTH+1); rd_gray SHALL be registered as next_bin ^ (next_bin >> 1).
REQ-021 When inflight = 1, mem_rd_data SHALL be written at the clock edge into the head entry if it is empty after pop, else into the skid entry.
REQ-022 On pop with occ = 2, the skid entry SHALL move to head in the same edge.
REQ-023 Transitions: occ_next = occ + inflight - pop. occ = 0 with pop is impossible by construction.
REQ-024 dout_valid SHALL be registered as (occ_next != 0).
REQ-025 dout SHALL be the head register and SHALL hold stable while dout_valid & ~dout_ready.
REQ-026 Latency: first word SHALL appear 2 cycles after wr_gray_sync leaves rd_gray (issue cycle + return cycle).
REQ-027 With continuous dout_ready and a non-empty RAM, throughput SHALL be 1 word per cycle.
REQ-028 level SHALL equal (gray2bin(wr_gray_sync) - rd_bin, width ADDR_WIDTH+1, mod 2^(ADDR_WIDTH+1)) + inflight + occ, zero-extended to ADDR_WIDTH+2.
REQ-029 Pointer wrap from 2^(ADDR_WIDTH+1)-1 to 0 SHALL be seamless; mem_rd_addr wraps to 0.

Reset
REQ-030 While rst = 1: rd_bin = 0, rd_gray = 0, inflight = 0, occ = 0 (state EMPTY), head = 0, skid = 0, dout_valid = 0, and mem_rd_en = 0.
REQ-031 Reset mid-operation SHALL discard buffered and in-flight data; mem_rd_data SHALL be ignored in the first cycle after release.

Structure
REQ-032 Shared package fifo_pkg SHALL hold the occ state encoding (EMPTY = 0, ONE = 1, TWO = 2) and the gray2bin and bin2gray functions.
REQ-033 gray2bin SHALL be one combinational sub-module, gray2bin, parameterised by width; all else stays inline.

Verification (ADDR_WIDTH = 4)
REQ-034 Release reset with wr_gray_sync = 00000 -> ram_empty = 1, mem_rd_en = 0, dout_valid = 0, and level = 0 for 10 cycles.
REQ-035 Set wr_gray_sync = 00001 with dout_ready = 0 -> mem_rd_en with addr 0 in cycle 0; dout_valid = 1 with RAM[0] in cycle 2; rd_bin = 1; level = 1.
REQ-036 Set wr_gray_sync = gray(5) = 00111 with dout_ready = 1 -> RAM[0..4] on 5 consecutive cycles, then dout_valid = 0 and level = 0.
REQ-037 Set wr_gray_sync = gray(16) = 11000 with dout_ready = 0 -> exactly 2 reads issued, rd_bin = 2, occ = 2, level = 16; raising dout_ready streams 16 words with no gap.
REQ-038 Preload rd_bin = 30 and stream 4 words -> addresses 14, 15, 0, 1; rd_bin sequence 30, 31, 0, 1, 2; rd_gray correct at each step.
REQ-039 Assert rst while occ = 2 and inflight = 1 -> all outputs at reset values immediately; no stale word after release.
